// File: rtl/adc_serial_pkg.sv
// Frame constants and state encoding shared by the ADC serial configuration
// writer and the read-back master.
package adc_serial_pkg;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_W     = 3;
    localparam int   DATA_W     = 9;
    localparam logic RW_READ    = 1'b1;

    // Master-driven header bits (R/W, address, reserved zeros) precede the data.
    localparam int   HDR_BITS   = FRAME_BITS - DATA_W;
    localparam int   HALF_PERS  = 2 * FRAME_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } ser_state_e;

    function automatic logic [FRAME_BITS-1:0] rd_frame(input logic [ADDR_W-1:0] addr);
        return {RW_READ, addr, 3'b000, {DATA_W{1'b0}}};
    endfunction

endpackage

// File: rtl/adc_reg_reader_if.sv
// Host request/response and ADC serial pin bundle for the register reader.
interface adc_reg_reader_if;
    import adc_serial_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] exp_data;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              mismatch;
    logic              sclk;
    logic              sload;
    logic              sdata_o;
    logic              sdata_oe;
    logic              sdata_i;

    // Host plus the ADC side of the pins.
    modport master (
        output rd_req, rd_addr, exp_data, sdata_i,
        input  rd_busy, rd_valid, rd_data, mismatch,
        input  sclk, sload, sdata_o, sdata_oe
    );

    // The reader itself.
    modport slave (
        input  rd_req, rd_addr, exp_data, sdata_i,
        output rd_busy, rd_valid, rd_data, mismatch,
        output sclk, sload, sdata_o, sdata_oe
    );

endinterface

// File: rtl/serial_clk_div.sv
// Half-period tick generator for the ADC serial port: tick_o marks the last
// clk cycle of each CLK_DIV-cycle half-period while enabled.
module serial_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    output logic                       tick_o,
    output logic [$clog2(CLK_DIV)-1:0] phase_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("serial_clk_div: CLK_DIV must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter parks at zero when disabled so every enable burst starts aligned.
    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o  = en_i && (cnt_q == LAST);
    assign phase_o = cnt_q;

endmodule

// File: rtl/adc_reg_reader.sv
// Serial read-back master for the ADC 3-wire configuration port: sends the
// read header, releases sdata, captures the 9-bit value and flags mismatch.
module adc_reg_reader
    import adc_serial_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    adc_reg_reader_if.slave bus
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [4:0] HP_LAST = 5'(HALF_PERS - 1);
    localparam logic [4:0] HP_TURN = 5'(2 * HDR_BITS);
    localparam logic [4:0] HP_RD0  = 5'(2 * HDR_BITS + 1);

    ser_state_e            state_q, state_d;
    logic [4:0]            hp_q, hp_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [DATA_W-1:0]     exp_q, exp_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  mismatch_q, mismatch_d;
    logic                  rd_valid_q, rd_busy_q;
    logic                  sclk_q, sload_q, sdo_q, oe_q;
    logic                  sclk_d, sload_d, sdo_d, oe_d;

    logic                  div_en, tick, sample, data_ne;
    logic [CW-1:0]         phase;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    serial_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (div_en),
        .tick_o  (tick),
        .phase_o (phase)
    );

    // First clk cycle of an odd half-period is the cycle sclk has just risen.
    assign sample  = (state_q == ST_SHIFT) && hp_q[0] && (hp_q >= HP_RD0) && (phase == '0);
    assign data_ne = (shreg_q != exp_q);

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        frame_d    = frame_q;
        exp_d      = exp_q;
        shreg_d    = shreg_q;
        rd_data_d  = rd_data_q;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    state_d = ST_SETUP;
                    hp_d    = '0;
                    frame_d = rd_frame(bus.rd_addr);
                    exp_d   = bus.exp_data;
                    shreg_d = '0;
                end
            end
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sample)
                    shreg_d = {shreg_q[DATA_W-2:0], bus.sdata_i};
                if (tick) begin
                    if (hp_q == HP_LAST) state_d = ST_HOLD;
                    else                 hp_d    = hp_q + 5'd1;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d    = ST_DONE;
                    rd_data_d  = shreg_q;
                    mismatch_d = data_ne;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are registered from the next state so they switch cleanly
    // on the same edge as the state they belong to.
    always_comb begin
        sload_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        sclk_d  = (state_d == ST_SHIFT) && hp_d[0];
        oe_d    = (state_d == ST_SETUP) || ((state_d == ST_SHIFT) && (hp_d < HP_TURN));
        sdo_d   = 1'b0;
        if (state_d == ST_SETUP)
            sdo_d = RW_READ;
        else if (oe_d)
            sdo_d = frame_q[~hp_d[4:1]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hp_q       <= '0;
            frame_q    <= '0;
            exp_q      <= '0;
            shreg_q    <= '0;
            rd_data_q  <= '0;
            mismatch_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_busy_q  <= 1'b0;
            sclk_q     <= 1'b0;
            sload_q    <= 1'b1;
            sdo_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            frame_q    <= frame_d;
            exp_q      <= exp_d;
            shreg_q    <= shreg_d;
            rd_data_q  <= rd_data_d;
            mismatch_q <= mismatch_d;
            rd_valid_q <= (state_d == ST_DONE);
            rd_busy_q  <= (state_d != ST_IDLE);
            sclk_q     <= sclk_d;
            sload_q    <= sload_d;
            sdo_q      <= sdo_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.rd_busy  = rd_busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.mismatch = mismatch_q;
    assign bus.sclk     = sclk_q;
    assign bus.sload    = sload_q;
    assign bus.sdata_o  = sdo_q;
    assign bus.sdata_oe = oe_q;

endmodule

// File: tb/tb_adc_reg_reader.sv
// Bench for adc_reg_reader: an ADC pin model answers read frames and a
// directed/random sequence checks data, mismatch, latency and bus turnaround.
module tb_adc_reg_reader;
    import adc_serial_pkg::*;

    localparam int CD  = 4;
    // Cycle of rd_valid, counting the cycle right after acceptance as 1.
    localparam int LAT = 34 * CD + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_reg_reader_if bus ();

    adc_reg_reader #(.CLK_DIV(CD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ADC model: records the header on sclk rises, drives data from the fall
    // after the 7th rise until sload goes high; also counts protocol violations.
    logic [8:0] adc_val = '0;
    logic       adc_oe = 1'b0, prev_sclk = 1'b0, prev_sload = 1'b1;
    logic [6:0] hdr_seen = '0;
    int         rises = 0, frames = 0, valids = 0, viol = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            adc_oe      = 1'b0;
            bus.sdata_i = 1'b0;
            prev_sclk   = 1'b0;
            prev_sload  = 1'b1;
            rises       = 0;
        end else begin
            if (bus.sload && bus.sclk) viol++;
            if (adc_oe && bus.sdata_oe) viol++;
            if (prev_sload && !bus.sload) begin
                frames++;
                rises    = 0;
                hdr_seen = '0;
                if (bus.sclk) viol++;
            end
            if (!prev_sload && bus.sload) begin
                adc_oe      = 1'b0;
                bus.sdata_i = 1'b0;
            end
            if (!prev_sclk && bus.sclk) begin
                if (rises < 7) begin
                    hdr_seen = {hdr_seen[5:0], bus.sdata_o};
                    if (!bus.sdata_oe) viol++;
                end
                rises++;
            end
            if (prev_sclk && !bus.sclk && !bus.sload && rises >= 7 && rises < 16) begin
                adc_oe      = 1'b1;
                bus.sdata_i = adc_val[4'(15 - rises)];
            end
            if (bus.rd_valid) valids++;
            prev_sclk  = bus.sclk;
            prev_sload = bus.sload;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sload"},    bus.sload,    1);
        chk({tag, "_sclk"},     bus.sclk,     0);
        chk({tag, "_oe"},       bus.sdata_oe, 0);
        chk({tag, "_sdo"},      bus.sdata_o,  0);
        chk({tag, "_busy"},     bus.rd_busy,  0);
        chk({tag, "_valid"},    bus.rd_valid, 0);
        chk({tag, "_rd_data"},  bus.rd_data,  0);
        chk({tag, "_mismatch"}, bus.mismatch, 0);
    endtask

    // Returns the cycle number of rd_valid; base is the cycle number now.
    task automatic wait_valid(input int base, output int lat);
        lat = -1;
        for (int i = 1; i <= 4 * LAT; i++) begin
            @(posedge clk); #1;
            if (bus.rd_valid) begin
                lat = base + i;
                break;
            end
        end
    endtask

    task automatic check_frame(input logic [2:0] a, input logic [8:0] e, input logic [8:0] v, input int lat);
        chk("latency",  lat,          LAT);
        chk("rd_data",  bus.rd_data,  v);
        chk("mismatch", bus.mismatch, v != e);
        chk("sclk_rises", rises,      16);
        chk("header",   hdr_seen,     {1'b1, a, 3'b000});
        chk("bus_viol", viol,         0);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [8:0] e, input logic [8:0] v);
        int lat;
        adc_val      = v;
        bus.rd_addr  = a;
        bus.exp_data = e;
        bus.rd_req   = 1'b1;
        @(posedge clk); #1;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = 3'($urandom);
        bus.exp_data = 9'($urandom);
        chk("busy_after_accept", bus.rd_busy, 1);
        wait_valid(1, lat);
        check_frame(a, e, v, lat);
        @(posedge clk); #1;
        chk("valid_pulse", bus.rd_valid, 0);
        chk("held_data",   bus.rd_data,  v);
    endtask

    initial begin
        int lat, f0, v0;
        logic [8:0] rv, re;
        logic [2:0] ra;

        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.exp_data = '0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        #1 chk_reset_outputs("reset");

        // Request during reset must not start a frame.
        bus.rd_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.rd_req = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_busy",   bus.rd_busy, 0);
        chk("post_reset_frames", frames,      0);

        do_read(3'b101, 9'h1A5, 9'h1A5);
        do_read(3'b101, 9'h1A5, 9'h1A4);
        do_read(3'b010, 9'h000, 9'h000);
        do_read(3'b111, 9'h1FF, 9'h1FF);

        for (int n = 0; n < 6; n++) begin
            ra = 3'($urandom);
            rv = 9'($urandom);
            re = ($urandom_range(0, 1) == 1) ? rv : 9'($urandom);
            do_read(ra, re, rv);
        end

        // Request for another address during a frame is ignored.
        f0 = frames; v0 = valids;
        adc_val = 9'h0F3; bus.rd_addr = 3'd6; bus.exp_data = 9'h0F3; bus.rd_req = 1'b1;
        @(posedge clk); #1 bus.rd_req = 1'b0;
        repeat (30) @(posedge clk);
        #1 bus.rd_addr = 3'd2; bus.rd_req = 1'b1;
        @(posedge clk); #1 bus.rd_req = 1'b0;
        wait_valid(32, lat);
        check_frame(3'd6, 9'h0F3, 9'h0F3, lat);
        repeat (200) @(posedge clk);
        #1;
        chk("busy_frames", frames - f0, 1);
        chk("busy_valids", valids - v0, 1);

        // rd_req held through DONE restarts after one idle cycle.
        adc_val = 9'h155; bus.rd_addr = 3'd3; bus.exp_data = 9'h155; bus.rd_req = 1'b1;
        @(posedge clk); #1;
        wait_valid(1, lat);
        check_frame(3'd3, 9'h155, 9'h155, lat);
        adc_val = 9'h0AA;
        @(posedge clk); #1;
        chk("b2b_idle_busy",  bus.rd_busy, 0);
        chk("b2b_idle_sload", bus.sload,   1);
        @(posedge clk); #1;
        chk("b2b_reaccept", bus.rd_busy, 1);
        bus.rd_req = 1'b0;
        wait_valid(1, lat);
        check_frame(3'd3, 9'h155, 9'h0AA, lat);
        @(posedge clk); #1;

        // Reset at half-period 20 drops everything including rd_data.
        adc_val = 9'h1FF; bus.rd_addr = 3'd1; bus.exp_data = 9'h000; bus.rd_req = 1'b1;
        @(posedge clk); #1 bus.rd_req = 1'b0;
        repeat (21 * CD) @(posedge clk);
        #1;
        chk("midreset_rises", rises,    10);
        chk("midreset_sload", bus.sload, 0);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_read(3'd7, 9'h0C3, 9'h0C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
